dual_load_ram_arbiter: RTL and testbench

//  Shares one TC_DualLoadRam between NUM_REQ requesters. Port0 carries reads and writes;

---
 rtl/dual_load_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dual_load_ram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_load_ram_arbiter.sv
// Arbiter sharing one dual-read RAM among NUM_REQ requesters: port0 read/write, port1 read-only,
// independent round-robin per port, registered read return, and a flush FSM that zeroes the RAM.
module dual_load_ram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 16,
    parameter int BIT_DEPTH = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_write,
    input  logic [NUM_REQ*16-1:0]          i_req_addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [NUM_REQ*BIT_WIDTH-1:0]   o_rsp_data,
    input  logic                           i_flush_req,
    output logic                           o_flush_busy,
    output logic                           o_flush_done,
    output logic                           o_ram_load0,
    output logic                           o_ram_save,
    output logic                           o_ram_load1,
    output logic [15:0]                    o_ram_address0,
    output logic [15:0]                    o_ram_address1,
    output logic [BIT_WIDTH-1:0]           o_ram_in,
    input  logic [BIT_WIDTH-1:0]           i_ram_out0,
    input  logic [BIT_WIDTH-1:0]           i_ram_out1
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {ST_ARB, ST_FLUSH} state_t;

    state_t r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_ptr0, r_ptr1;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0][BIT_WIDTH-1:0] r_rsp_data;

    logic [NUM_REQ-1:0][15:0] w_addr_a;
    logic [NUM_REQ-1:0][BIT_WIDTH-1:0] w_wdata_a;
    logic w_arb_en, w_gnt0, w_cand1, w_gnt1, w_in0, w_in1, w_rd0;
    logic [PW-1:0] w_win0, w_win1;
    logic [15:0] w_addr0, w_addr1;

    assign w_addr_a  = i_req_addr;
    assign w_wdata_a = i_req_wdata;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        return PW'((int'(base) + k) % NUM_REQ);
    endfunction

    // A pending flush request takes the whole cycle; reset blocks any accept.
    assign w_arb_en = (r_state == ST_ARB) && !i_flush_req && !i_rst;

    always_comb begin
        w_gnt0  = 1'b0;
        w_win0  = '0;
        w_cand1 = 1'b0;
        w_win1  = '0;
        if (w_arb_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_gnt0 && i_req_valid[rr_idx(r_ptr0, k)]) begin
                    w_gnt0 = 1'b1;
                    w_win0 = rr_idx(r_ptr0, k);
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_cand1 && i_req_valid[rr_idx(r_ptr1, k)] && !i_req_write[rr_idx(r_ptr1, k)]
                    && !(w_gnt0 && (w_win0 == rr_idx(r_ptr1, k)))) begin
                    w_cand1 = 1'b1;
                    w_win1  = rr_idx(r_ptr1, k);
                end
            end
        end
    end

    assign w_addr0 = w_addr_a[w_win0];
    assign w_addr1 = w_addr_a[w_win1];
    assign w_in0   = {16'd0, w_addr0} < 32'(BIT_DEPTH);
    assign w_in1   = {16'd0, w_addr1} < 32'(BIT_DEPTH);
    assign w_rd0   = w_gnt0 && !i_req_write[w_win0];
    // A port1 read racing a port0 write to the same word would see pre-commit data; hold it off.
    assign w_gnt1  = w_cand1 && !(w_gnt0 && i_req_write[w_win0] && (w_addr0 == w_addr1));

    always_comb begin
        o_req_ready    = '0;
        o_ram_load0    = 1'b0;
        o_ram_save     = 1'b0;
        o_ram_load1    = 1'b0;
        o_ram_address0 = '0;
        o_ram_address1 = '0;
        o_ram_in       = '0;
        if (r_state == ST_FLUSH) begin
            o_ram_save     = 1'b1;
            o_ram_address0 = r_cnt;
        end else begin
            if (w_gnt0) begin
                o_req_ready[w_win0] = 1'b1;
                o_ram_address0      = w_addr0;
                if (i_req_write[w_win0]) begin
                    o_ram_save = w_in0;
                    o_ram_in   = w_wdata_a[w_win0];
                end else begin
                    o_ram_load0 = w_in0;
                end
            end
            if (w_gnt1) begin
                o_req_ready[w_win1] = 1'b1;
                o_ram_load1         = w_in1;
                o_ram_address1      = w_addr1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARB: begin
                if (i_flush_req) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (r_cnt == 16'(BIT_DEPTH - 1)) begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_flush_busy = (r_state == ST_FLUSH);
    assign o_flush_done = (r_state == ST_FLUSH) && (r_cnt == 16'(BIT_DEPTH - 1));
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ARB;
            r_cnt       <= '0;
            r_ptr0      <= '0;
            r_ptr1      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= '0;
            if (w_gnt0) r_ptr0 <= rr_idx(w_win0, 1);
            if (w_gnt1) r_ptr1 <= rr_idx(w_win1, 1);
            // Out-of-range reads never load the RAM, so they return zero.
            if (w_rd0) begin
                r_rsp_valid[w_win0] <= 1'b1;
                r_rsp_data[w_win0]  <= w_in0 ? i_ram_out0 : '0;
            end
            if (w_gnt1) begin
                r_rsp_valid[w_win1] <= 1'b1;
                r_rsp_data[w_win1]  <= w_in1 ? i_ram_out1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_dual_load_ram_arbiter.sv
// Directed bench for dual_load_ram_arbiter with a behavioural dual-read RAM
// (negedge write commit, combinational reads, 0xDEAD for out-of-range addresses).
module tb_dual_load_ram_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] valid, wr, ready, rsp_valid;
    logic [N-1:0][15:0] addr_a;
    logic [N-1:0][W-1:0] wd_a, rsp_data_a;
    logic [N*W-1:0] rsp_data;
    logic flush_req, busy, done, load0, save, load1;
    logic [15:0] a0, a1;
    logic [W-1:0] ram_in, ram_out0, ram_out1;
    logic init_mem;
    logic [W-1:0] mem [0:D-1];
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_rdy [0:3];

    always #5 clk = ~clk;

    dual_load_ram_arbiter #(.NUM_REQ(N), .BIT_WIDTH(W), .BIT_DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid), .i_req_write(wr), .i_req_addr(addr_a), .i_req_wdata(wd_a),
        .o_req_ready(ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .i_flush_req(flush_req), .o_flush_busy(busy), .o_flush_done(done),
        .o_ram_load0(load0), .o_ram_save(save), .o_ram_load1(load1),
        .o_ram_address0(a0), .o_ram_address1(a1), .o_ram_in(ram_in),
        .i_ram_out0(ram_out0), .i_ram_out1(ram_out1)
    );

    assign rsp_data_a = rsp_data;

    always @(negedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < D; i++) mem[i] = 16'hA000 + 16'(i);
        end else if (save && a0 < 16'(D)) begin
            mem[a0[7:0]] = ram_in;
        end
    end
    assign ram_out0 = (a0 < 16'(D)) ? mem[a0[7:0]] : 16'hDEAD;
    assign ram_out1 = (a1 < 16'(D)) ? mem[a1[7:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid = '0; wr = '0; addr_a = '0; wd_a = '0; flush_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_rdy[0] = 4'b0011; exp_rdy[1] = 4'b0110; exp_rdy[2] = 4'b1100; exp_rdy[3] = 4'b1001;
        init_mem = 1'b1;
        clr();
        tick(); tick();
        init_mem = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_ram_ctl", 64'({load0, save, load1}), 0);
        chk("rst_ram_addr", 64'({a0, a1}), 0);
        chk("rst_flush", 64'({busy, done}), 0);

        // write then read the same word
        tick();
        valid[0] = 1'b1; wr[0] = 1'b1; addr_a[0] = 16'd5; wd_a[0] = 16'h1234; #1;
        chk("t1_wr_ready", 64'(ready), 64'b0001);
        chk("t1_wr_ctl", 64'({save, load0, load1}), 64'b100);
        chk("t1_wr_addr", 64'(a0), 5);
        chk("t1_wr_data", 64'(ram_in), 64'h1234);
        tick(); clr();
        valid[1] = 1'b1; addr_a[1] = 16'd5; #1;
        chk("t1_wr_norsp", 64'(rsp_valid), 0);
        chk("t1_rd_ready", 64'(ready), 64'b0010);
        chk("t1_rd_ctl", 64'({save, load0, load1}), 64'b010);
        tick(); clr(); #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("t1_rsp_data", 64'(rsp_data_a[1]), 64'h1234);

        // four continuous readers from fresh pointers
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b1; addr_a[i] = 16'(10 + i);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_ready", 64'(ready), 64'(exp_rdy[k]));
            tick();
            chk("t2_rsp_valid", 64'(rsp_valid), 64'(exp_rdy[k]));
            for (int i = 0; i < N; i++)
                if (exp_rdy[k][i]) chk("t2_rsp_data", 64'(rsp_data_a[i]), 64'(16'hA00A + 16'(i)));
        end
        clr();

        // same-address write/read collision: the read is deferred
        valid[0] = 1'b1; wr[0] = 1'b1; addr_a[0] = 16'd7; wd_a[0] = 16'hBEEF;
        valid[1] = 1'b1; addr_a[1] = 16'd7; #1;
        chk("t3_ready", 64'(ready), 64'b0001);
        chk("t3_load1", 64'(load1), 0);
        tick();
        valid[0] = 1'b0; wr[0] = 1'b0; #1;
        chk("t3_defer_ready", 64'(ready), 64'b0010);
        tick(); clr(); #1;
        chk("t3_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("t3_rsp_data", 64'(rsp_data_a[1]), 64'hBEEF);

        // out-of-range addresses
        valid[2] = 1'b1; addr_a[2] = 16'd256; #1;
        chk("t4_rd_ready", 64'(ready), 64'b0100);
        chk("t4_rd_load0", 64'(load0), 0);
        tick(); clr(); #1;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'b0100);
        chk("t4_rsp_data", 64'(rsp_data_a[2]), 0);
        valid[3] = 1'b1; wr[3] = 1'b1; addr_a[3] = 16'd300; wd_a[3] = 16'h5555; #1;
        chk("t4_wr_ready", 64'(ready), 64'b1000);
        chk("t4_wr_save", 64'(save), 0);
        tick(); clr();
        valid[0] = 1'b1; addr_a[0] = 16'd12;
        valid[1] = 1'b1; addr_a[1] = 16'd300; #1;
        chk("t4_dual_ready", 64'(ready), 64'b0011);
        chk("t4_dual_load", 64'({load0, load1}), 64'b10);
        tick(); clr(); #1;
        chk("t4_dual_rsp_valid", 64'(rsp_valid), 64'b0011);
        chk("t4_dual_rsp0", 64'(rsp_data_a[0]), 64'hA00C);
        chk("t4_dual_rsp1", 64'(rsp_data_a[1]), 0);

        // fill, then flush
        for (int a = 0; a < 4; a++) begin
            valid[0] = 1'b1; wr[0] = 1'b1; addr_a[0] = 16'(a); wd_a[0] = 16'h1110 + 16'(a); #1;
            chk("t5_fill", 64'({ready, save}), 64'b00011);
            tick();
        end
        clr();
        flush_req = 1'b1;
        valid[0] = 1'b1; addr_a[0] = 16'd1; #1;
        chk("t5_req_cycle_ready", 64'(ready), 0);
        chk("t5_req_cycle_ctl", 64'({busy, load0, save, load1}), 0);
        tick();
        flush_req = 1'b0;
        for (int n = 0; n < D; n++) begin
            chk("t5_flush_ctl", 64'({busy, done, ready, save, load0, load1}),
                64'({1'b1, (n == D - 1), 4'b0000, 1'b1, 1'b0, 1'b0}));
            chk("t5_flush_addr", 64'({a0, ram_in}), 64'({16'(n), 16'h0000}));
            if (n == 10) flush_req = 1'b1;
            if (n == 11) flush_req = 1'b0;
            tick();
        end
        chk("t5_after_busy", 64'({busy, done}), 0);
        chk("t5_after_ready", 64'(ready), 64'b0001);
        tick(); clr(); #1;
        chk("t5_rd1_valid", 64'(rsp_valid), 64'b0001);
        chk("t5_rd1_data", 64'(rsp_data_a[0]), 0);
        valid[3] = 1'b1; addr_a[3] = 16'd3; #1;
        tick(); clr(); #1;
        chk("t5_rd3_valid", 64'(rsp_valid), 64'b1000);
        chk("t5_rd3_data", 64'(rsp_data_a[3]), 0);

        // reset in the middle of a flush
        valid[0] = 1'b1; wr[0] = 1'b1; addr_a[0] = 16'd9; wd_a[0] = 16'h7777; #1;
        tick(); clr();
        valid[2] = 1'b1; addr_a[2] = 16'd9; #1;
        tick(); clr(); #1;
        chk("t6_pre_data", 64'(rsp_data_a[2]), 64'h7777);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (100) tick();
        chk("t6_mid_flush", 64'({busy, a0}), 64'({1'b1, 16'd100}));
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("t6_flush_state", 64'({busy, done}), 0);
        chk("t6_ram_ctl", 64'({load0, save, load1, a0}), 0);
        chk("t6_ready", 64'(ready), 0);
        chk("t6_rsp_valid", 64'(rsp_valid), 0);
        chk("t6_rsp_data", 64'(rsp_data), 0);
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b1; addr_a[i] = 16'(10 + i);
        end
        #1;
        chk("t6_ptr_ready", 64'(ready), 64'b0011);
        tick(); clr(); #1;
        chk("t6_ptr_rsp", 64'(rsp_valid), 64'b0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
